// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Contents:
//   state_t    - loader FSM states
//   WORD_BYTES - bytes per instruction word in the input stream
//   N_ALL      - header value that means "load the whole memory"
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [7:0] N_ALL      = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into one big-endian 32-bit word.
// Ports:
//   clk_i     in   system clock
//   rst_i     in   asynchronous active-high reset
//   shift_en  in   accept byte_in this cycle
//   clear     in   restart word assembly (byte counter to 0)
//   byte_in   in   8-bit stream byte
//   word      out  shift register contents, first byte ends up in 31:24
//   last_byte out  the next accepted byte completes the word
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            shift_q  <= {shift_q[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word      = shift_q;
    assign last_byte = (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: reads a length-prefixed byte stream and writes it into the
// instruction memory, holding the CPU in reset until the image is complete.
// Stream: header N (0 means DEPTH words), then 4*N bytes, big-endian words.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           begin a load (honoured in IDLE, DONE, ERR)
//   byte_i            stream byte, byte_valid_i qualifies it
//   byte_ready_o      loader accepts a byte this cycle (LEN, DATA only)
//   wr_en_o           one-cycle memory write strobe
//   wr_addr_o         word address of the write
//   wr_data_o         word to write
//   cpu_rst_o         active-low CPU reset; 1 only in DONE
//   busy_o, done_o, error_o  status flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [31:0]       pk_word;
    logic              pk_last;
    logic              transfer;
    logic              len_ok;

    // Ready depends on state alone so the source can never see a
    // combinational path from its own valid back to ready.
    assign byte_ready_o = (state == LEN) || (state == DATA);
    assign transfer     = byte_valid_i && byte_ready_o;
    // Header 0 (N_ALL) passes trivially and is expanded to DEPTH below.
    assign len_ok       = ({1'b0, byte_i} <= 9'(DEPTH));

    imem_word_packer u_packer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .shift_en  ((state == DATA) && transfer),
        .clear     ((state == WRITE) || (state == LEN)),
        .byte_in   (byte_i),
        .word      (pk_word),
        .last_byte (pk_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output and next-state signal gets a default before the
    // case statement, so no path leaves one unassigned and no latch appears.
    always_comb begin
        state_nxt = state;
        wr_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        error_o   = 1'b0;
        cpu_rst_o = 1'b0;
        case (state)
            IDLE: if (start_i) state_nxt = LEN;
            LEN: begin
                busy_o = 1'b1;
                if (transfer) state_nxt = len_ok ? DATA : ERR;
            end
            DATA: begin
                busy_o = 1'b1;
                if (transfer && pk_last) state_nxt = WRITE;
            end
            WRITE: begin
                busy_o    = 1'b1;
                wr_en_o   = 1'b1;
                state_nxt = (addr_q == last_addr_q) ? DONE : DATA;
            end
            DONE: begin
                done_o    = 1'b1;
                cpu_rst_o = 1'b1;
                if (start_i) state_nxt = LEN;
            end
            ERR: begin
                error_o = 1'b1;
                if (start_i) state_nxt = LEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address bookkeeping plus write-port holding registers. The write port
    // is loaded on the completing byte so it is stable for the whole WRITE
    // cycle and keeps its value until the next word finishes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if ((state == LEN) && transfer && len_ok) begin
                addr_q      <= '0;
                last_addr_q <= (byte_i == N_ALL) ? ADDR_W'(DEPTH - 1)
                                                 : ADDR_W'(byte_i - 8'd1);
            end
            if ((state == DATA) && transfer && pk_last) begin
                wr_addr_q <= addr_q;
                wr_data_q <= {pk_word[23:0], byte_i};
            end
            // Never steps past last_addr_q, so the counter cannot wrap.
            if ((state == WRITE) && (addr_q != last_addr_q))
                addr_q <= addr_q + 1'b1;
        end
    end

    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
